// File: rtl/plab5_mcore_mem_req_split_pkg.sv
// Shared definitions for the memory-request splitter.
//   - request type encodings carried in the top bits of every memory request
//   - field-width helpers for the type/opaque/addr/len control fields
//   - control message width derived from the opaque/addr/data widths
package plab5_mcore_mem_req_split_pkg;

    localparam int unsigned TYPE_NBITS  = 3;
    localparam int unsigned QUEUE_DEPTH = 2;

    typedef enum logic [TYPE_NBITS-1:0] {
        MEMREQ_READ    = 3'd0,
        MEMREQ_WRITE   = 3'd1,
        MEMREQ_AMO_ADD = 3'd2,
        MEMREQ_AMO_AND = 3'd3,
        MEMREQ_AMO_OR  = 3'd4
    } memreq_type_e;

    // len counts bytes within one data beat
    function automatic int unsigned len_nbits(input int unsigned data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

    // control message = {type, opaque, addr, len}
    function automatic int unsigned ctrl_nbits(input int unsigned opaque_nbits,
                                               input int unsigned addr_nbits,
                                               input int unsigned data_nbits);
        return TYPE_NBITS + opaque_nbits + addr_nbits + len_nbits(data_nbits);
    endfunction

endpackage

// File: rtl/plab5_mcore_dom_queue2.sv
// Two-entry FIFO with a security-domain bit stored alongside every entry.
// Outputs are forced to zero whenever the queue is empty so a stale entry
// left in storage by another domain can never be observed downstream.
//   clk, reset      : clock, asynchronous active-low reset
//   enq_val_i/rdy_o : enqueue handshake, enq_msg_i/enq_domain_i payload
//   deq_val_o/rdy_i : dequeue handshake, deq_msg_o/deq_domain_o head entry
module plab5_mcore_dom_queue2
    import plab5_mcore_mem_req_split_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val_i,
    output logic               enq_rdy_o,
    input  logic [p_nbits-1:0] enq_msg_i,
    input  logic               enq_domain_i,
    output logic               deq_val_o,
    input  logic               deq_rdy_i,
    output logic [p_nbits-1:0] deq_msg_o,
    output logic               deq_domain_o
);

    logic [p_nbits-1:0] msg_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] dom_q;
    logic enq_ptr_q, enq_ptr_d;
    logic deq_ptr_q, deq_ptr_d;
    logic [1:0] count_q, count_d;
    logic enq_fire, deq_fire;

    // Full blocks enqueue even when a dequeue happens in the same cycle.
    assign enq_rdy_o = (count_q != 2'(QUEUE_DEPTH));
    assign deq_val_o = (count_q != 2'd0);
    assign enq_fire  = enq_val_i && enq_rdy_o;
    assign deq_fire  = deq_val_o && deq_rdy_i;

    assign deq_msg_o    = deq_val_o ? msg_q[deq_ptr_q] : '0;
    assign deq_domain_o = deq_val_o ? dom_q[deq_ptr_q] : 1'b0;

    always_comb begin
        // 1-bit pointers wrap 1 -> 0 on their own
        enq_ptr_d = enq_ptr_q ^ enq_fire;
        deq_ptr_d = deq_ptr_q ^ deq_fire;
        count_d   = count_q;
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr_q <= 1'b0;
            deq_ptr_q <= 1'b0;
            count_q   <= 2'd0;
            dom_q     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
            if (enq_fire) begin
                msg_q[enq_ptr_q] <= enq_msg_i;
                dom_q[enq_ptr_q] <= enq_domain_i;
            end
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_req_split.sv
// Splits a full memory request {type, opaque, addr, len, data} into a
// control message and, for every non-read type, a data beat. Each part is
// buffered in its own 2-entry domain-tagged queue.
//   clk, reset                          : clock, asynchronous active-low reset
//   memreq_val/rdy/msg/domain           : full request in
//   ctrl_val/rdy/msg/domain             : control message out
//   data_val/rdy/msg/domain             : data beat out
module plab5_mcore_mem_req_split
    import plab5_mcore_mem_req_split_pkg::*;
#(
    parameter  int unsigned p_opaque_nbits = 8,
    parameter  int unsigned p_addr_nbits   = 32,
    parameter  int unsigned p_data_nbits   = 32,
    localparam int unsigned c_nbits        = ctrl_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int unsigned req_nbits      = c_nbits + p_data_nbits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memreq_val,
    output logic                    memreq_rdy,
    input  logic [req_nbits-1:0]    memreq_msg,
    input  logic                    memreq_domain,
    output logic                    ctrl_val,
    input  logic                    ctrl_rdy,
    output logic [c_nbits-1:0]      ctrl_msg,
    output logic                    ctrl_domain,
    output logic                    data_val,
    input  logic                    data_rdy,
    output logic [p_data_nbits-1:0] data_msg,
    output logic                    data_domain
);

    memreq_type_e      req_type;
    logic              req_fire;
    logic              ctrl_enq_rdy, data_enq_rdy;
    logic              data_enq_val;

    assign req_type = memreq_type_e'(memreq_msg[req_nbits-1 -: TYPE_NBITS]);

    // Both queues must have room, so a data queue full of write beats also
    // stalls reads. Depends on queue state only.
    assign memreq_rdy   = ctrl_enq_rdy && data_enq_rdy;
    assign req_fire     = memreq_val && memreq_rdy;
    assign data_enq_val = req_fire && (req_type != MEMREQ_READ);

    plab5_mcore_dom_queue2 #(
        .p_nbits (c_nbits)
    ) u_ctrl_q (
        .clk          (clk),
        .reset        (reset),
        .enq_val_i    (req_fire),
        .enq_rdy_o    (ctrl_enq_rdy),
        .enq_msg_i    (memreq_msg[req_nbits-1:p_data_nbits]),
        .enq_domain_i (memreq_domain),
        .deq_val_o    (ctrl_val),
        .deq_rdy_i    (ctrl_rdy),
        .deq_msg_o    (ctrl_msg),
        .deq_domain_o (ctrl_domain)
    );

    plab5_mcore_dom_queue2 #(
        .p_nbits (p_data_nbits)
    ) u_data_q (
        .clk          (clk),
        .reset        (reset),
        .enq_val_i    (data_enq_val),
        .enq_rdy_o    (data_enq_rdy),
        .enq_msg_i    (memreq_msg[p_data_nbits-1:0]),
        .enq_domain_i (memreq_domain),
        .deq_val_o    (data_val),
        .deq_rdy_i    (data_rdy),
        .deq_msg_o    (data_msg),
        .deq_domain_o (data_domain)
    );

endmodule

// File: tb/tb_plab5_mcore_mem_req_split.sv
module tb_plab5_mcore_mem_req_split;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [76:0] memreq_msg;
    logic        memreq_domain;
    logic        ctrl_val;
    logic        ctrl_rdy;
    logic [44:0] ctrl_msg;
    logic        ctrl_domain;
    logic        data_val;
    logic        data_rdy;
    logic [31:0] data_msg;
    logic        data_domain;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    plab5_mcore_mem_req_split dut (
        .clk           (clk),
        .reset         (reset),
        .memreq_val    (memreq_val),
        .memreq_rdy    (memreq_rdy),
        .memreq_msg    (memreq_msg),
        .memreq_domain (memreq_domain),
        .ctrl_val      (ctrl_val),
        .ctrl_rdy      (ctrl_rdy),
        .ctrl_msg      (ctrl_msg),
        .ctrl_domain   (ctrl_domain),
        .data_val      (data_val),
        .data_rdy      (data_rdy),
        .data_msg      (data_msg),
        .data_domain   (data_domain)
    );

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic        dom;
        logic [44:0] exp_ctrl;
        logic        exp_dval;
        logic [31:0] exp_data;
        logic        exp_ddom;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        return {t, o, a, l, d};
    endfunction

    task automatic send(input logic [76:0] msg, input logic dom);
        memreq_val    = 1'b1;
        memreq_msg    = msg;
        memreq_domain = dom;
        tick();
        memreq_val    = 1'b0;
    endtask

    logic [76:0] il_msg [3];
    logic        il_dom [3];
    logic [31:0] beat_data [$];
    logic        beat_dom  [$];

    initial begin
        vecs[0] = '{3'd0, 8'h11, 32'h0000_1000, 2'd0, 32'hCAFE_F00D, 1'b1,
                    {3'd0, 8'h11, 32'h0000_1000, 2'd0}, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{3'd1, 8'h22, 32'h0000_2004, 2'd3, 32'hDEAD_BEEF, 1'b0,
                    {3'd1, 8'h22, 32'h0000_2004, 2'd3}, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{3'd2, 8'hFF, 32'hFFFF_FFFC, 2'd2, 32'h0000_0001, 1'b1,
                    {3'd2, 8'hFF, 32'hFFFF_FFFC, 2'd2}, 1'b1, 32'h0000_0001, 1'b1};
        vecs[3] = '{3'd7, 8'h00, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, 1'b0,
                    {3'd7, 8'h00, 32'h8000_0000, 2'd1}, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{3'd0, 8'hA5, 32'h1234_5678, 2'd1, 32'h1234_5678, 1'b0,
                    {3'd0, 8'hA5, 32'h1234_5678, 2'd1}, 1'b0, 32'h0, 1'b0};

        reset = 1'b0; memreq_val = 1'b0; memreq_msg = '0; memreq_domain = 1'b0;
        ctrl_rdy = 1'b0; data_rdy = 1'b0;
        repeat (2) tick();
        check("rst_ctrl_val", 64'(ctrl_val), 64'd0);
        check("rst_data_val", 64'(data_val), 64'd0);
        reset = 1'b1;
        tick();
        check("rel_outputs", {ctrl_val, data_val, ctrl_domain, data_domain, ctrl_msg == 45'd0, data_msg == 32'd0},
              64'b000011);
        check("rel_rdy", 64'(memreq_rdy), 64'd1);

        // single requests: enqueue, observe next cycle, drain
        for (int i = 0; i < 5; i++) begin
            ctrl_rdy = 1'b0; data_rdy = 1'b0;
            send(mk_req(vecs[i].typ, vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].data), vecs[i].dom);
            check($sformatf("v%0d_ctrl_val", i), 64'(ctrl_val), 64'd1);
            check($sformatf("v%0d_ctrl_msg", i), 64'(ctrl_msg), 64'(vecs[i].exp_ctrl));
            check($sformatf("v%0d_ctrl_dom", i), 64'(ctrl_domain), 64'(vecs[i].dom));
            check($sformatf("v%0d_data_val", i), 64'(data_val), 64'(vecs[i].exp_dval));
            check($sformatf("v%0d_data_msg", i), 64'(data_msg), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_data_dom", i), 64'(data_domain), 64'(vecs[i].exp_ddom));
            ctrl_rdy = 1'b1; data_rdy = 1'b1;
            tick();
            check($sformatf("v%0d_drained", i), {ctrl_val, data_val, ctrl_msg == 45'd0, data_msg == 32'd0}, 64'b0011);
        end

        // write, dequeue ctrl only: data beat stays
        ctrl_rdy = 1'b0; data_rdy = 1'b0;
        send(mk_req(3'd1, 8'h05, 32'h0000_2004, 2'd0, 32'hDEAD_BEEF), 1'b0);
        ctrl_rdy = 1'b1;
        tick();
        ctrl_rdy = 1'b0;
        check("wr_ctrl_gone", 64'(ctrl_val), 64'd0);
        check("wr_data_kept", {data_val, data_domain, data_msg}, {1'b1, 1'b0, 32'hDEAD_BEEF});
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        check("wr_data_gone", 64'(data_val), 64'd0);

        // ctrl full with two reads; a third is refused
        send(mk_req(3'd0, 8'h01, 32'h10, 2'd0, 32'h0), 1'b0);
        send(mk_req(3'd0, 8'h02, 32'h20, 2'd0, 32'h0), 1'b0);
        check("full_rdy_low", 64'(memreq_rdy), 64'd0);
        send(mk_req(3'd0, 8'h03, 32'h30, 2'd0, 32'h0), 1'b0);
        check("full_head", 64'(ctrl_msg), 64'({3'd0, 8'h01, 32'h10, 2'd0}));
        check("full_no_data", 64'(data_val), 64'd0);
        ctrl_rdy = 1'b1;
        #1;
        check("full_rdy_same_cycle", 64'(memreq_rdy), 64'd0);
        tick();
        ctrl_rdy = 1'b0;
        check("full_rdy_next_cycle", 64'(memreq_rdy), 64'd1);
        check("full_head2", 64'(ctrl_msg), 64'({3'd0, 8'h02, 32'h20, 2'd0}));
        ctrl_rdy = 1'b1;
        tick();
        ctrl_rdy = 1'b0;
        check("full_third_refused", 64'(ctrl_val), 64'd0);

        // data queue full of writes stalls a read
        ctrl_rdy = 1'b1; data_rdy = 1'b0;
        send(mk_req(3'd1, 8'h40, 32'h40, 2'd0, 32'h1111_1111), 1'b1);
        send(mk_req(3'd1, 8'h41, 32'h44, 2'd0, 32'h2222_2222), 1'b0);
        check("dfull_rdy_low", 64'(memreq_rdy), 64'd0);
        check("dfull_head", {data_val, data_domain, data_msg}, {1'b1, 1'b1, 32'h1111_1111});
        data_rdy = 1'b1;
        repeat (2) tick();
        ctrl_rdy = 1'b0; data_rdy = 1'b0;
        check("dfull_drained", {ctrl_val, data_val, memreq_rdy}, 64'b001);

        // back-to-back writes at full throughput
        ctrl_rdy = 1'b1; data_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            memreq_val    = 1'b1;
            memreq_msg    = mk_req(3'd1, 8'(i), 32'h100 + 32'(4 * i), 2'd0, 32'hA000_0000 + 32'(i));
            memreq_domain = 1'(i);
            tick();
            check($sformatf("b2b%0d_rdy", i), 64'(memreq_rdy), 64'd1);
            check($sformatf("b2b%0d_ctrl", i), {ctrl_val, ctrl_msg},
                  {1'b1, 3'd1, 8'(i), 32'h100 + 32'(4 * i), 2'd0});
            check($sformatf("b2b%0d_data", i), {data_val, data_domain, data_msg},
                  {1'b1, 1'(i), 32'hA000_0000 + 32'(i)});
        end
        memreq_val = 1'b0;
        tick();
        check("b2b_empty", {ctrl_val, data_val}, 64'd0);

        // interleaved read/write/amo with random downstream stalls
        il_msg[0] = mk_req(3'd0, 8'h70, 32'h700, 2'd0, 32'h7777_7777); il_dom[0] = 1'b1;
        il_msg[1] = mk_req(3'd1, 8'h71, 32'h704, 2'd0, 32'hBEEF_0001); il_dom[1] = 1'b0;
        il_msg[2] = mk_req(3'd2, 8'h72, 32'h708, 2'd0, 32'hBEEF_0002); il_dom[2] = 1'b1;
        begin
            int sent = 0;
            int ctrl_got = 0;
            bit done = 0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                ctrl_rdy   = 1'($urandom_range(0, 1));
                data_rdy   = 1'($urandom_range(0, 1));
                memreq_val = (sent < 3);
                if (sent < 3) begin
                    memreq_msg    = il_msg[sent];
                    memreq_domain = il_dom[sent];
                end
                #1;
                if (!ctrl_val) check("il_ctrl_scrub", {ctrl_domain, ctrl_msg}, 64'd0);
                if (!data_val) check("il_data_scrub", {data_domain, data_msg}, 64'd0);
                if (data_val && data_rdy) begin
                    beat_data.push_back(data_msg);
                    beat_dom.push_back(data_domain);
                end
                if (ctrl_val && ctrl_rdy) ctrl_got++;
                if (memreq_val && memreq_rdy) sent++;
                tick();
                done = (sent == 3) && (ctrl_got == 3) && !ctrl_val && !data_val;
            end
            memreq_val = 1'b0; ctrl_rdy = 1'b0; data_rdy = 1'b0;
            check("il_completed", 64'(done), 64'd1);
            check("il_ctrl_count", 64'(ctrl_got), 64'd3);
        end
        check("il_beat_count", 64'(beat_data.size()), 64'd2);
        if (beat_data.size() == 2) begin
            check("il_beat0", {beat_dom[0], beat_data[0]}, {1'b0, 32'hBEEF_0001});
            check("il_beat1", {beat_dom[1], beat_data[1]}, {1'b1, 32'hBEEF_0002});
        end

        // reset mid-stream with two entries queued
        send(mk_req(3'd1, 8'h90, 32'h900, 2'd0, 32'h9999_0000), 1'b1);
        send(mk_req(3'd1, 8'h91, 32'h904, 2'd0, 32'h9999_0001), 1'b1);
        check("mid_full", {ctrl_val, data_val, memreq_rdy}, 64'b110);
        #1 reset = 1'b0;
        #1;
        check("mid_async_drop", {ctrl_val, data_val, ctrl_domain, data_domain, ctrl_msg == 45'd0, data_msg == 32'd0},
              64'b000011);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("mid_after_rel", {memreq_rdy, ctrl_val, data_val}, 64'b100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
